// File: rtl/jtcop_obj_dma_pkg.sv
// Shared constants and FSM encoding for the object-table DMA.
package jtcop_obj_dma_pkg;

    localparam int OBJ_AW = 10;
    localparam int OBJ_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_FLUSH = 2'd2
    } dma_state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module jtframe_dual_ram #(
    parameter int DW = 16,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= mem[raddr];
    end

endmodule

// File: rtl/jtcop_obj_dma.sv
// Object-table DMA: copies object RAM into the back bank of a double-buffered
// table and swaps banks at vblank start once a complete copy is pending.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | no copy running; waiting for dma_trig
// ST_COPY  | reading object RAM, src_addr advancing every cycle
// ST_FLUSH | last word in flight; written this cycle, then pend set
module jtcop_obj_dma
    import jtcop_obj_dma_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          dma_trig,
    output logic          dma_busy,
    output logic          src_cs,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_dout,
    input  logic [AW-1:0] tbl_addr,
    output logic [DW-1:0] tbl_dout,
    output logic          bank
);

    dma_state_t    state, state_nxt;
    logic          lvl;
    logic          vb_edge;
    logic          swap;
    logic          pend;
    logic          cs_d;
    logic [AW-1:0] addr_d;
    logic          last;

    assign last    = &src_addr;
    assign vb_edge = lvl & ~LVBL;
    // A swap always uses the pend value from before this cycle's trigger
    assign swap    = vb_edge & pend;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a trigger restarts the copy from any state
    always_comb begin
        state_nxt = state;
        if (dma_trig) begin
            state_nxt = ST_COPY;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_COPY:  state_nxt = last ? ST_FLUSH : ST_COPY;
                ST_FLUSH: state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the state
    always_comb begin
        src_cs   = (state == ST_COPY);
        dma_busy = (state != ST_IDLE);
    end

    // Source address counter; holds at all-ones while the last word flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              src_addr <= '0;
        else if (dma_trig)                    src_addr <= '0;
        else if (state == ST_COPY && !last)   src_addr <= src_addr + AW'(1);
    end

    // Read-to-write pipeline: object RAM data arrives one clock after the address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_d   <= 1'b0;
            addr_d <= '0;
        end else begin
            cs_d   <= src_cs;
            addr_d <= src_addr;
        end
    end

    // Vblank edge detector, pending-copy flag and bank toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl  <= 1'b0;
            pend <= 1'b0;
            bank <= 1'b0;
        end else begin
            lvl <= LVBL;
            if (swap) bank <= ~bank;
            if (dma_trig)               pend <= 1'b0;
            else if (state == ST_FLUSH) pend <= 1'b1;
            else if (swap)              pend <= 1'b0;
        end
    end

    jtframe_dual_ram #(
        .DW (DW),
        .AW (AW + 1)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cs_d),
        .waddr ({~bank, addr_d}),
        .wdata (src_dout),
        .raddr ({bank, tbl_addr}),
        .q     (tbl_dout)
    );

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Self-checking bench for jtcop_obj_dma with a scoreboard on the table read port.
module tb_jtcop_obj_dma;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          LVBL;
    logic          dma_trig;
    logic          dma_busy;
    logic          src_cs;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_dout;
    logic [AW-1:0] tbl_addr;
    logic [DW-1:0] tbl_dout;
    logic          bank;

    logic [DW-1:0] src_mem [0:N-1];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Object RAM model: one-clock read latency
    always @(posedge clk) begin
        if (src_cs) src_dout <= src_mem[src_addr];
    end

    jtcop_obj_dma #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .LVBL     (LVBL),
        .dma_trig (dma_trig),
        .dma_busy (dma_busy),
        .src_cs   (src_cs),
        .src_addr (src_addr),
        .src_dout (src_dout),
        .tbl_addr (tbl_addr),
        .tbl_dout (tbl_dout),
        .bank     (bank)
    );

    task automatic fill_src(input logic [DW-1:0] x, input bit xor_index);
        for (int i = 0; i < N; i++) src_mem[i] = xor_index ? (DW'(i) ^ x) : x;
    endtask

    task automatic pulse_trig();
        @(negedge clk) dma_trig = 1'b1;
        @(negedge clk) dma_trig = 1'b0;
    endtask

    task automatic vblank();
        @(negedge clk) LVBL = 1'b0;
        repeat (3) @(negedge clk);
        LVBL = 1'b1;
        @(negedge clk);
    endtask

    // Counts busy cycles starting at the current negedge
    task automatic measure_busy(output int n);
        n = 0;
        while (dma_busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (dma_busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (dma_busy) begin
            fails++;
            $display("FAIL %s: timeout, dma_busy=%0b required 0", name, dma_busy);
        end
    endtask

    // Scoreboard producer: drive address, push expectation, capture DUT output
    task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        @(negedge clk) tbl_addr = a;
        exp_q.push_back(e);
        @(posedge clk) #1;
        got_q.push_back(tbl_dout);
    endtask

    task automatic test_reset();
        rst = 1'b1; LVBL = 1'b1; dma_trig = 1'b0; tbl_addr = '0;
        repeat (3) @(negedge clk);
        tests += 5;
        if (dma_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b need 0", dma_busy); end
        if (src_cs   !== 1'b0) begin fails++; $display("FAIL reset_cs: got %b need 0", src_cs); end
        if (src_addr !== '0)   begin fails++; $display("FAIL reset_addr: got %h need 0", src_addr); end
        if (bank     !== 1'b0) begin fails++; $display("FAIL reset_bank: got %b need 0", bank); end
        if (tbl_dout !== '0)   begin fails++; $display("FAIL reset_dout: got %h need 0", tbl_dout); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_copy();
        int n;
        logic [DW-1:0] e, g;
        fill_src(16'h5A00, 1'b1);
        pulse_trig();
        tests += 2;
        if (src_cs !== 1'b1) begin fails++; $display("FAIL copy_cs_start: got %b need 1", src_cs); end
        if (src_addr !== '0) begin fails++; $display("FAIL copy_addr_start: got %h need 0", src_addr); end
        measure_busy(n);
        tests++;
        if (n != 1025) begin fails++; $display("FAIL copy_busy_len: got %0d need 1025", n); end
        vblank();
        tests++;
        if (bank !== 1'b1) begin fails++; $display("FAIL copy_bank: got %b need 1", bank); end
        issue_read(10'd0,    16'h5A00);
        issue_read(10'd1,    16'h5A01);
        issue_read(10'd1023, 16'h59FF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL copy_data: got %h need %h", g, e); end
        end
    endtask

    task automatic test_deferred_swap();
        logic [DW-1:0] e, g;
        fill_src(16'hA5A5, 1'b1);
        pulse_trig();
        repeat (198) @(negedge clk);
        vblank();
        tests++;
        if (bank !== 1'b1) begin fails++; $display("FAIL defer_no_swap: got %b need 1", bank); end
        issue_read(10'd2, 16'h5A02);
        wait_idle("defer_idle");
        vblank();
        tests++;
        if (bank !== 1'b0) begin fails++; $display("FAIL defer_swap: got %b need 0", bank); end
        issue_read(10'd0,    16'hA5A5);
        issue_read(10'd5,    16'hA5A0);
        issue_read(10'd1023, 16'hA5A5 ^ 16'h03FF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL defer_data: got %h need %h", g, e); end
        end
    endtask

    task automatic test_retrigger();
        int n, k;
        logic [DW-1:0] e, g;
        fill_src(16'h0BAD, 1'b1);
        pulse_trig();
        k = 0;
        while (src_addr != 10'd500 && k < 2000) begin k++; @(negedge clk); end
        tests++;
        if (src_addr != 10'd500) begin fails++; $display("FAIL retrig_reach: got %0d need 500", src_addr); end
        fill_src(16'h1234, 1'b0);
        dma_trig = 1'b1;
        @(negedge clk) dma_trig = 1'b0;
        measure_busy(n);
        tests++;
        if (n != 1025) begin fails++; $display("FAIL retrig_busy_len: got %0d need 1025", n); end
        vblank();
        tests++;
        if (bank !== 1'b1) begin fails++; $display("FAIL retrig_bank: got %b need 1", bank); end
        for (int i = 0; i < N; i++) issue_read(AW'(i), 16'h1234);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL retrig_data: got %h need %h", g, e); end
        end
    endtask

    task automatic test_no_trigger();
        logic [DW-1:0] e, g;
        vblank();
        vblank();
        tests++;
        if (bank !== 1'b1) begin fails++; $display("FAIL notrig_bank: got %b need 1", bank); end
        issue_read(10'd0,   16'h1234);
        issue_read(10'd777, 16'h1234);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL notrig_data: got %h need %h", g, e); end
        end
    endtask

    task automatic test_coincident();
        logic [DW-1:0] e, g;
        fill_src(16'h0F0F, 1'b1);
        pulse_trig();
        wait_idle("coin_first_idle");
        fill_src(16'h7777, 1'b1);
        @(negedge clk);
        LVBL = 1'b0; dma_trig = 1'b1;
        @(negedge clk) dma_trig = 1'b0;
        tests += 2;
        if (bank !== 1'b0)     begin fails++; $display("FAIL coin_bank: got %b need 0", bank); end
        if (dma_busy !== 1'b1) begin fails++; $display("FAIL coin_busy: got %b need 1", dma_busy); end
        LVBL = 1'b1;
        issue_read(10'd0,    16'h0F0F);
        issue_read(10'd10,   16'h0F05);
        issue_read(10'd1023, 16'h0F0F ^ 16'h03FF);
        wait_idle("coin_idle");
        issue_read(10'd300,  16'h0F0F ^ 16'd300);
        vblank();
        tests++;
        if (bank !== 1'b1) begin fails++; $display("FAIL coin_bank2: got %b need 1", bank); end
        issue_read(10'd0,    16'h7777);
        issue_read(10'd1023, 16'h7777 ^ 16'h03FF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL coin_data: got %h need %h", g, e); end
        end
    endtask

    task automatic test_reset_mid_copy();
        int k;
        fill_src(16'h3C3C, 1'b1);
        pulse_trig();
        k = 0;
        while (src_addr != 10'd300 && k < 2000) begin k++; @(negedge clk); end
        rst = 1'b1;
        #1;
        tests += 4;
        if (dma_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b need 0", dma_busy); end
        if (src_cs   !== 1'b0) begin fails++; $display("FAIL rstmid_cs: got %b need 0", src_cs); end
        if (bank     !== 1'b0) begin fails++; $display("FAIL rstmid_bank: got %b need 0", bank); end
        if (src_addr !== '0)   begin fails++; $display("FAIL rstmid_addr: got %h need 0", src_addr); end
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        vblank();
        tests += 2;
        if (bank !== 1'b0)     begin fails++; $display("FAIL rstmid_noswap: got %b need 0", bank); end
        if (dma_busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got %b need 0", dma_busy); end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_deferred_swap();
        test_retrigger();
        test_no_trigger();
        test_coincident();
        test_reset_mid_copy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
